// File: rtl/rs232_cmd_responder_if.sv
// Signal bundle between the command responder, the UART byte interface and the register bus.
// master = responder side, slave = UART / register-file side.
interface rs232_cmd_responder_if;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic [7:0] TX_DATA;
   logic       TX_START;
   logic       TX_BUSY;
   logic [7:0] REG_ADDR;
   logic [7:0] REG_WDATA;
   logic       REG_WE;
   logic       REG_RE;
   logic [7:0] REG_RDATA;
   logic       FRAME_ERR;

   modport master (
      input  RX_DATA, RX_VALID, TX_BUSY, REG_RDATA,
      output TX_DATA, TX_START, REG_ADDR, REG_WDATA, REG_WE, REG_RE, FRAME_ERR
   );

   modport slave (
      output RX_DATA, RX_VALID, TX_BUSY, REG_RDATA,
      input  TX_DATA, TX_START, REG_ADDR, REG_WDATA, REG_WE, REG_RE, FRAME_ERR
   );
endinterface

// File: rtl/rs232_cmd_responder.sv
// Assembles 3-byte flow/addr/data frames from the UART into register-bus writes and reads,
// returning read data as a single transmitted byte.
module rs232_cmd_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                   CLK_50MHZ,
   input  logic                   RST,
   rs232_cmd_responder_if.master  bus
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWaitAddr,
      StWaitData,
      StExecWr,
      StExecRd,
      StRdCapture,
      StSend,
      StSendHold
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic            rd_frame_q;
   logic [7:0]      tx_data_q;
   logic            tx_start_q;
   logic [7:0]      reg_addr_q;
   logic [7:0]      reg_wdata_q;
   logic            reg_we_q;
   logic            reg_re_q;

   logic waiting;
   logic expired;

   assign waiting = (state_q == StWaitAddr) || (state_q == StWaitData);
   // Expiry is decoded in the cycle the count sits at its last value, so it beats a
   // coincident byte and the error pulse lands exactly TIMEOUT_CYCLES after the last byte.
   assign expired = waiting && (cnt_q == CntLast);

   always_ff @(posedge CLK_50MHZ) begin
      if (RST) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rd_frame_q  <= 1'b0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
      end else begin
         reg_we_q   <= 1'b0;
         reg_re_q   <= 1'b0;
         tx_start_q <= 1'b0;
         if (waiting && (cnt_q != CntLast)) begin
            cnt_q <= cnt_q + 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (bus.RX_VALID) begin
                  rd_frame_q <= bus.RX_DATA[0];
                  cnt_q      <= '0;
                  state_q    <= StWaitAddr;
               end
            end
            StWaitAddr: begin
               if (expired) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else if (bus.RX_VALID) begin
                  reg_addr_q <= bus.RX_DATA;
                  cnt_q      <= '0;
                  state_q    <= StWaitData;
               end
            end
            StWaitData: begin
               if (expired) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else if (bus.RX_VALID) begin
                  cnt_q <= '0;
                  if (rd_frame_q) begin
                     reg_re_q <= 1'b1;
                     state_q  <= StExecRd;
                  end else begin
                     reg_wdata_q <= bus.RX_DATA;
                     reg_we_q    <= 1'b1;
                     state_q     <= StExecWr;
                  end
               end
            end
            StExecWr: state_q <= StIdle;
            StExecRd: state_q <= StRdCapture;
            // Start request is registered one state early so it appears the cycle after
            // the transmitter is seen idle.
            StRdCapture: begin
               tx_data_q <= bus.REG_RDATA;
               if (!bus.TX_BUSY) begin
                  tx_start_q <= 1'b1;
                  state_q    <= StSendHold;
               end else begin
                  state_q <= StSend;
               end
            end
            StSend: begin
               if (!bus.TX_BUSY) begin
                  tx_start_q <= 1'b1;
                  state_q    <= StSendHold;
               end
            end
            StSendHold: state_q <= StIdle;
            default:    state_q <= StIdle;
         endcase
      end
   end

   assign bus.TX_DATA   = tx_data_q;
   assign bus.TX_START  = tx_start_q;
   assign bus.REG_ADDR  = reg_addr_q;
   assign bus.REG_WDATA = reg_wdata_q;
   assign bus.REG_WE    = reg_we_q;
   assign bus.REG_RE    = reg_re_q;
   assign bus.FRAME_ERR = expired;

endmodule

// File: tb/tb_rs232_cmd_responder.sv
// Bench for rs232_cmd_responder: directed frame scenarios plus randomized frames checked
// against a register-array model of what the host's frames should do.
module tb_rs232_cmd_responder;

   localparam int unsigned T = 30;

   typedef struct {
      int         cyc;
      logic [7:0] a;
      logic [7:0] d;
   } ev_t;

   logic CLK_50MHZ = 1'b0;
   logic RST;

   rs232_cmd_responder_if bus ();

   rs232_cmd_responder #(.TIMEOUT_CYCLES(T)) dut (
      .CLK_50MHZ (CLK_50MHZ),
      .RST       (RST),
      .bus       (bus)
   );

   always #10 CLK_50MHZ = ~CLK_50MHZ;

   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   int         viol = 0;
   ev_t        we_q[$];
   ev_t        re_q[$];
   ev_t        tx_q[$];
   int         err_q[$];
   logic [7:0] regfile [256];
   logic [7:0] model [256];

   initial forever begin
      @(posedge CLK_50MHZ);
      cyc++;
   end

   // Observes the DUT mid-cycle, logs strobes and plays the register file.
   initial begin : monitor
      logic prev_start;
      prev_start = 1'b0;
      forever begin
         @(negedge CLK_50MHZ);
         if (bus.REG_WE) begin
            we_q.push_back('{cyc, bus.REG_ADDR, bus.REG_WDATA});
            regfile[bus.REG_ADDR] = bus.REG_WDATA;
         end
         if (bus.REG_RE)    re_q.push_back('{cyc, bus.REG_ADDR, 8'h00});
         if (bus.TX_START)  tx_q.push_back('{cyc, 8'h00, bus.TX_DATA});
         if (bus.FRAME_ERR) err_q.push_back(cyc);
         if (bus.REG_WE && bus.REG_RE) viol++;
         if (bus.TX_START && prev_start) viol++;
         prev_start = bus.TX_START;
      end
   end

   // Read data is presented only in the cycle after REG_RE; junk otherwise.
   initial begin : rdata_drv
      logic [7:0] a;
      bus.REG_RDATA = 8'($urandom);
      forever begin
         @(negedge CLK_50MHZ);
         if (bus.REG_RE) begin
            a = bus.REG_ADDR;
            @(posedge CLK_50MHZ);
            #1 bus.REG_RDATA = regfile[a];
            @(posedge CLK_50MHZ);
            #1 bus.REG_RDATA = 8'($urandom);
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation still running at time %0t, limit reached", $time);
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK_50MHZ);
   endtask

   // Called at a falling edge; the byte is valid for the current cycle, whose number is returned.
   task automatic send_byte(input logic [7:0] b, output int c);
      bus.RX_DATA  = b;
      bus.RX_VALID = 1'b1;
      c = cyc;
      @(negedge CLK_50MHZ);
      bus.RX_VALID = 1'b0;
      bus.RX_DATA  = 8'($urandom);
   endtask

   task automatic clear_logs;
      we_q.delete();
      re_q.delete();
      tx_q.delete();
      err_q.delete();
   endtask

   task automatic test_reset;
      RST = 1'b1;
      idle(3);
      n_tests++;
      if ({bus.TX_DATA, bus.REG_ADDR, bus.REG_WDATA} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 000000",
                  {bus.TX_DATA, bus.REG_ADDR, bus.REG_WDATA});
      end
      n_tests++;
      if ({bus.TX_START, bus.REG_WE, bus.REG_RE, bus.FRAME_ERR} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_strobes: got %b want 0000",
                  {bus.TX_START, bus.REG_WE, bus.REG_RE, bus.FRAME_ERR});
      end
      RST = 1'b0;
      idle(1);
   endtask

   task automatic test_write;
      int c, n;
      clear_logs();
      send_byte(8'h00, c);
      idle(2);
      send_byte(8'h7B, c);
      idle(0);
      send_byte(8'h02, n);
      idle(6);
      model[8'h7B] = 8'h02;
      n_tests++;
      if (we_q.size() != 1) begin
         n_fail++;
         $display("FAIL write_we_count: got %0d want 1", we_q.size());
      end else begin
         n_tests++;
         if (we_q[0].cyc != n + 1 || we_q[0].a !== 8'h7B || we_q[0].d !== 8'h02) begin
            n_fail++;
            $display("FAIL write_we: got cyc %0d a %h d %h want cyc %0d a 7b d 02",
                     we_q[0].cyc, we_q[0].a, we_q[0].d, n + 1);
         end
      end
      n_tests++;
      if (re_q.size() + tx_q.size() + err_q.size() != 0) begin
         n_fail++;
         $display("FAIL write_extra: got re %0d tx %0d err %0d want 0 0 0",
                  re_q.size(), tx_q.size(), err_q.size());
      end
   endtask

   task automatic test_read;
      int c, n;
      regfile[8'hEA] = 8'hA5;
      model[8'hEA]   = 8'hA5;
      clear_logs();
      send_byte(8'h01, c);
      send_byte(8'hEA, c);
      idle(3);
      send_byte(8'hFF, n);
      idle(8);
      n_tests++;
      if (re_q.size() != 1 || re_q[0].cyc != n + 1 || re_q[0].a !== 8'hEA) begin
         n_fail++;
         $display("FAIL read_re: got count %0d cyc %0d a %h want 1 cyc %0d a ea",
                  re_q.size(), (re_q.size() > 0) ? re_q[0].cyc : -1,
                  (re_q.size() > 0) ? re_q[0].a : 8'h00, n + 1);
      end
      n_tests++;
      if (tx_q.size() != 1 || tx_q[0].cyc != n + 3 || tx_q[0].d !== 8'hA5) begin
         n_fail++;
         $display("FAIL read_tx: got count %0d cyc %0d d %h want 1 cyc %0d d a5",
                  tx_q.size(), (tx_q.size() > 0) ? tx_q[0].cyc : -1,
                  (tx_q.size() > 0) ? tx_q[0].d : 8'h00, n + 3);
      end
      n_tests++;
      if (we_q.size() != 0) begin
         n_fail++;
         $display("FAIL read_no_we: got %0d want 0", we_q.size());
      end
   endtask

   task automatic test_read_busy;
      int c, n, rel;
      bit stable;
      clear_logs();
      bus.TX_BUSY = 1'b1;
      send_byte(8'h01, c);
      send_byte(8'hEA, c);
      send_byte(8'hFF, n);
      stable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (cyc >= n + 3 && bus.TX_DATA !== 8'hA5) stable = 1'b0;
         idle(1);
      end
      n_tests++;
      if (tx_q.size() != 0) begin
         n_fail++;
         $display("FAIL busy_early_start: got %0d starts want 0", tx_q.size());
      end
      bus.TX_BUSY = 1'b0;
      rel = cyc;
      idle(1);
      if (bus.TX_DATA !== 8'hA5) stable = 1'b0;
      idle(6);
      n_tests++;
      if (!stable) begin
         n_fail++;
         $display("FAIL busy_tx_stable: got unstable TX_DATA want a5 held");
      end
      n_tests++;
      if (tx_q.size() != 1 || tx_q[0].cyc != rel + 1 || tx_q[0].d !== 8'hA5) begin
         n_fail++;
         $display("FAIL busy_tx: got count %0d cyc %0d want 1 cyc %0d",
                  tx_q.size(), (tx_q.size() > 0) ? tx_q[0].cyc : -1, rel + 1);
      end
   endtask

   task automatic test_timeout;
      int c, n;
      clear_logs();
      send_byte(8'h00, c);
      send_byte(8'h10, n);
      idle(T + 5);
      n_tests++;
      if (err_q.size() != 1 || err_q[0] != n + T) begin
         n_fail++;
         $display("FAIL timeout_err: got count %0d cyc %0d want 1 cyc %0d",
                  err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, n + T);
      end
      n_tests++;
      if (we_q.size() != 0) begin
         n_fail++;
         $display("FAIL timeout_no_we: got %0d want 0", we_q.size());
      end
      // Longest legal gaps must not expire.
      clear_logs();
      send_byte(8'h00, c);
      idle(T - 2);
      send_byte(8'h11, c);
      idle(T - 2);
      send_byte(8'h22, n);
      idle(4);
      model[8'h11] = 8'h22;
      n_tests++;
      if (we_q.size() != 1 || we_q[0].a !== 8'h11 || we_q[0].d !== 8'h22 || err_q.size() != 0)
      begin
         n_fail++;
         $display("FAIL timeout_recover: got we %0d err %0d want we 1 (11<-22) err 0",
                  we_q.size(), err_q.size());
      end
      // A byte landing on the expiry cycle is dropped.
      clear_logs();
      send_byte(8'h00, c);
      idle(T - 1);
      send_byte(8'h33, n);
      send_byte(8'h00, c);
      send_byte(8'h44, c);
      send_byte(8'h55, c);
      idle(4);
      model[8'h44] = 8'h55;
      n_tests++;
      if (err_q.size() != 1 || err_q[0] != n) begin
         n_fail++;
         $display("FAIL expiry_tie_err: got count %0d cyc %0d want 1 cyc %0d",
                  err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, n);
      end
      n_tests++;
      if (we_q.size() != 1 || we_q[0].a !== 8'h44 || we_q[0].d !== 8'h55) begin
         n_fail++;
         $display("FAIL expiry_tie_we: got count %0d a %h want 1 a 44 d 55",
                  we_q.size(), (we_q.size() > 0) ? we_q[0].a : 8'h00);
      end
   endtask

   task automatic test_reset_midframe;
      int c, n;
      clear_logs();
      send_byte(8'h00, c);
      send_byte(8'h7B, c);
      RST = 1'b1;
      idle(2);
      n_tests++;
      if ({bus.TX_DATA, bus.REG_ADDR, bus.REG_WDATA, bus.TX_START, bus.REG_WE, bus.REG_RE,
           bus.FRAME_ERR} !== 28'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got addr %h wdata %h tx %h want all zero",
                  bus.REG_ADDR, bus.REG_WDATA, bus.TX_DATA);
      end
      RST = 1'b0;
      idle(T + 3);
      n_tests++;
      if (we_q.size() + err_q.size() != 0) begin
         n_fail++;
         $display("FAIL midreset_aborted: got we %0d err %0d want 0 0",
                  we_q.size(), err_q.size());
      end
      send_byte(8'h00, c);
      send_byte(8'h12, c);
      send_byte(8'h34, n);
      idle(4);
      model[8'h12] = 8'h34;
      n_tests++;
      if (we_q.size() != 1 || we_q[0].cyc != n + 1 || we_q[0].a !== 8'h12 ||
          we_q[0].d !== 8'h34) begin
         n_fail++;
         $display("FAIL midreset_next_frame: got count %0d want 1 write 12<-34 at %0d",
                  we_q.size(), n + 1);
      end
   endtask

   task automatic test_back_to_back;
      int c, n;
      clear_logs();
      send_byte(8'h00, c);
      send_byte(8'h01, c);
      send_byte(8'h05, c);
      idle(1);
      model[8'h01] = 8'h05;
      bus.TX_BUSY = 1'b1;
      send_byte(8'h01, c);
      send_byte(8'h01, c);
      send_byte(8'hFF, n);
      idle(2);
      send_byte(8'h01, c);       // lands while waiting to send
      bus.TX_BUSY = 1'b0;
      idle(T + 5);
      n_tests++;
      if (we_q.size() != 1 || we_q[0].a !== 8'h01 || we_q[0].d !== 8'h05) begin
         n_fail++;
         $display("FAIL b2b_we: got count %0d want 1 write 01<-05", we_q.size());
      end
      n_tests++;
      if (tx_q.size() != 1 || tx_q[0].d !== 8'h05 || tx_q[0].cyc != n + 5) begin
         n_fail++;
         $display("FAIL b2b_tx: got count %0d d %h cyc %0d want 1 d 05 cyc %0d",
                  tx_q.size(), (tx_q.size() > 0) ? tx_q[0].d : 8'h00,
                  (tx_q.size() > 0) ? tx_q[0].cyc : -1, n + 5);
      end
      n_tests++;
      if (re_q.size() != 1 || err_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_injected_byte: got re %0d err %0d want 1 0",
                  re_q.size(), err_q.size());
      end
   endtask

   task automatic test_random;
      int c, n, rel, g1, g2, bd, exp_tx;
      logic       rd;
      logic [7:0] addr, data, last_wd;
      bit         have_wd;
      have_wd = 1'b0;
      last_wd = 8'h00;
      for (int f = 0; f < 24; f++) begin
         rd   = 1'($urandom);
         addr = 8'($urandom);
         data = 8'($urandom);
         g1   = $urandom_range(0, T - 2);
         g2   = $urandom_range(0, T - 2);
         bd   = rd ? $urandom_range(0, 5) : 0;
         clear_logs();
         send_byte({7'($urandom), rd}, c);
         idle(g1);
         send_byte(addr, c);
         idle(g2);
         if (bd > 0) bus.TX_BUSY = 1'b1;
         send_byte(data, n);
         idle(bd);
         bus.TX_BUSY = 1'b0;
         rel = cyc;
         idle(8);
         if (!rd) begin
            model[addr] = data;
            last_wd = data;
            have_wd = 1'b1;
            n_tests++;
            if (we_q.size() != 1 || we_q[0].cyc != n + 1 || we_q[0].a !== addr ||
                we_q[0].d !== data || re_q.size() != 0 || tx_q.size() != 0) begin
               n_fail++;
               $display("FAIL rand_write[%0d]: got we %0d re %0d tx %0d want 1 write %h<-%h",
                        f, we_q.size(), re_q.size(), tx_q.size(), addr, data);
            end
         end else begin
            exp_tx = (rel + 1 > n + 3) ? rel + 1 : n + 3;
            n_tests++;
            if (re_q.size() != 1 || re_q[0].cyc != n + 1 || re_q[0].a !== addr ||
                we_q.size() != 0) begin
               n_fail++;
               $display("FAIL rand_read_re[%0d]: got re %0d we %0d want re 1 at %h",
                        f, re_q.size(), we_q.size(), addr);
            end
            n_tests++;
            if (tx_q.size() != 1 || tx_q[0].cyc != exp_tx || tx_q[0].d !== model[addr]) begin
               n_fail++;
               $display("FAIL rand_read_tx[%0d]: got count %0d cyc %0d d %h want cyc %0d d %h",
                        f, tx_q.size(), (tx_q.size() > 0) ? tx_q[0].cyc : -1,
                        (tx_q.size() > 0) ? tx_q[0].d : 8'h00, exp_tx, model[addr]);
            end
         end
         n_tests++;
         if (bus.REG_ADDR !== addr || err_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_hold_addr[%0d]: got addr %h err %0d want addr %h err 0",
                     f, bus.REG_ADDR, err_q.size(), addr);
         end
         if (have_wd) begin
            n_tests++;
            if (bus.REG_WDATA !== last_wd) begin
               n_fail++;
               $display("FAIL rand_hold_wdata[%0d]: got %h want %h", f, bus.REG_WDATA, last_wd);
            end
         end
      end
   endtask

   task automatic test_invariants;
      n_tests++;
      if (viol != 0) begin
         n_fail++;
         $display("FAIL strobe_invariants: got %0d violations want 0", viol);
      end
   endtask

   initial begin : main
      for (int i = 0; i < 256; i++) begin
         regfile[i] = 8'($urandom);
         model[i]   = regfile[i];
      end
      RST          = 1'b1;
      bus.RX_DATA  = 8'h00;
      bus.RX_VALID = 1'b0;
      bus.TX_BUSY  = 1'b0;
      @(negedge CLK_50MHZ);
      test_reset();
      test_write();
      test_read();
      test_read_busy();
      test_timeout();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rs232_cmd_responder.md
# rs232_cmd_responder

FPGA-side responder for the 3-byte serial command protocol driven by the host over RS232. It takes byte strobes from the UART receiver and assembles frames of flow, address and data. Write frames become a single-cycle register-bus write; read frames become a register-bus read, and the read value is returned as one byte through the UART transmitter. The block sits between the UART and the scoreboard register file.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1_000_000: maximum idle gap between bytes of one frame (20 ms at 50 MHz). The partial frame is discarded when it expires.

Ports:
- CLK_50MHZ  in  1  sole clock, 50 MHz; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- RX_DATA  in  8  received byte; valid only while RX_VALID=1
- RX_VALID  in  1  one-cycle strobe per received byte
- TX_DATA  out  8  byte to transmit; held stable from TX_START until TX_BUSY falls
- TX_START  out  1  one-cycle transmit request
- TX_BUSY  in  1  transmitter busy; must be high by the cycle after TX_START
- REG_ADDR  out  8  register address
- REG_WDATA  out  8  write data
- REG_WE  out  1  one-cycle write strobe
- REG_RE  out  1  one-cycle read strobe
- REG_RDATA  in  8  read data, valid exactly 1 cycle after REG_RE
- FRAME_ERR  out  1  one-cycle pulse on inter-byte timeout

## Operation
- Frame format: byte0 = flow, byte1 = addr, byte2 = data.
  - flow[0]=0 is a write; flow[0]=1 is a read.
  - flow[7:1] is reserved and ignored.
  - In read frames the data byte is a dummy (host sends 0xFF) and is discarded.
- States:
  - IDLE: RX_VALID latches flow, clears the timeout counter, goes to WAIT_ADDR.
  - WAIT_ADDR: RX_VALID latches addr and goes to WAIT_DATA. Timeout goes to IDLE with FRAME_ERR.
  - WAIT_DATA: RX_VALID latches data. Goes to EXEC_WR if flow[0]=0, else EXEC_RD. Timeout goes to IDLE with FRAME_ERR.
  - EXEC_WR: REG_WE=1 for one cycle, then IDLE.
  - EXEC_RD: REG_RE=1 for one cycle, then RD_CAPTURE.
  - RD_CAPTURE: TX_DATA <= REG_RDATA, then SEND.
  - SEND: waits while TX_BUSY=1. When TX_BUSY=0, pulses TX_START and goes to SEND_HOLD.
  - SEND_HOLD: one cycle, then IDLE.
- Timeout counter:
  - Cleared on every accepted byte; runs only in WAIT_ADDR and WAIT_DATA.
  - Expires when the count reaches TIMEOUT_CYCLES-1. Width is clog2(TIMEOUT_CYCLES); it saturates and never wraps.
- Bytes arriving in EXEC_*, RD_CAPTURE, SEND or SEND_HOLD are dropped silently; they are not buffered. The next frame starts at the first RX_VALID seen in IDLE.
- RX_VALID in the same cycle as timeout expiry: timeout wins and the byte is dropped.
- REG_ADDR and REG_WDATA hold their last latched values between frames.

## Timing
- Reset values: TX_DATA=0, TX_START=0, REG_ADDR=0, REG_WDATA=0, REG_WE=0, REG_RE=0, FRAME_ERR=0; state IDLE; timeout counter 0. RST mid-frame aborts the frame with no strobes.
- Write: data byte RX_VALID at cycle N gives REG_WE=1 at N+1 with REG_ADDR and REG_WDATA valid in that cycle. Ready for a new frame from N+2.
- Read: data byte at cycle N gives REG_RE at N+1, REG_RDATA sampled at N+2, and TX_START at N+3 if TX_BUSY=0. With TX_BUSY=1, TX_START comes in the first cycle after TX_BUSY falls.
- TX_START is never high for two consecutive cycles. REG_WE and REG_RE are never high together.
- FRAME_ERR pulses in the expiry cycle, i.e. TIMEOUT_CYCLES cycles after the last accepted byte.

## Test plan
- Write frame 0x00,0x7B,0x02 -> exactly one REG_WE pulse with REG_ADDR=0x7B, REG_WDATA=0x02; no TX_START; no REG_RE.
- Read frame 0x01,0xEA,0xFF with REG_RDATA=0xA5 -> REG_RE at N+1 with REG_ADDR=0xEA; TX_START at N+3 with TX_DATA=0xA5; no REG_WE.
- Read with TX_BUSY held high 40 cycles after REG_RE -> TX_START exactly 1 cycle after TX_BUSY falls; TX_DATA=0xA5 stable throughout.
- Bytes 0x00,0x10 then silence -> FRAME_ERR pulse TIMEOUT_CYCLES cycles after 0x10, no REG_WE. A following frame 0x00,0x11,0x22 then writes 0x22 to 0x11.
- RST asserted after the address byte of a write -> no REG_WE; all outputs at reset values; the next full frame executes normally.
- Two back-to-back frames (write 0x05 to 0x01, then read 0x01 with bench echoing the register) -> one REG_WE, then TX_DATA=0x05. A byte injected during SEND is ignored.
